cas_player: RTL and testbench
=============================

Name: cas_player

Overview:
- Virtual cassette deck: streams a loaded .CAS image to the machine's cassette input (casdout) as a CoCo/Dragon FSK waveform.
- Bit 0 = one cycle at 1200 Hz; bit 1 = one cycle at 2400 Hz; bytes sent LSB first.
- Transmitter counterpart to the PIA1 cassette-input path.
- Fetches bytes from the tape image buffer over a req/ack read port; playback is gated by the machine's motor relay (cas_relay).

Parameters:
- HALF0, 17898, clk cycles per half-period of a 0 bit (1200 Hz at 42.954 MHz)
- HALF1, 8949, clk cycles per half-period of a 1 bit (2400 Hz)
- SPINUP, 21477273, clk cycles of low output after motor-on before first byte (0.5 s)
- AW, 24, tape image address width

Ports:
- clk  in  1  system clock, 42.954 MHz
- reset  in  1  synchronous, active-low
- motor  in  1  cassette relay from PIA1 CA2; 1 = playing
- rewind  in  1  pulse; return to byte 0
- file_size  in  AW  image length in bytes; sampled at rewind and at reset release
- rd_req  out  1  byte fetch request, held until rd_ack
- rd_addr  out  AW  byte address, stable while rd_req is high
- rd_data  in  8  fetched byte, valid with rd_ack
- rd_ack  in  1  one-cycle acknowledge, no fixed latency
- casdout  out  1  FSK square wave to the machine
- audio  out  12  monitor tone: 12'h400 when casdout=1, else 12'h000
- playing  out  1  high in SPIN, FETCH, WAIT, BITHI, BITLO
- eot  out  1  end of tape reached
- position  out  AW  index of next byte to fetch

Behaviour:
- Reset (reset=0) values: casdout=0, audio=0, rd_req=0, rd_addr=0, position=0, playing=0, eot=0, state=IDLE. Size latch loads file_size.
- IDLE
  - motor=1 and position<size -> SPIN with the counter cleared.
  - motor=1 and position>=size (includes size 0) -> EOT.
- SPIN: casdout=0. Counts SPINUP cycles with motor=1, then -> FETCH. motor=0 during SPIN -> IDLE; the next motor-on restarts the full spin-up.
- FETCH: assert rd_req with rd_addr=position -> WAIT. rd_req rises the cycle after entry.
- WAIT: hold rd_req until rd_ack.
  - On ack: latch rd_data into the shift register, bitcnt=0, position+=1, drop rd_req the same cycle -> BITHI.
  - The fetch always completes even if motor falls; no dangling request.
- BITHI: casdout=1 for HALF(bit) cycles (HALF1 if shreg[0], else HALF0) -> BITLO.
- BITLO: casdout=0 for the same half count.
  - At end: shift right, bitcnt+1.
  - If bitcnt was 7: -> FETCH when position<size, else -> EOT.
  - Otherwise -> BITHI.
- Motor pause: motor=0 in BITHI/BITLO freezes the half-period counter, casdout level and bitcnt. motor=1 resumes exactly where it stopped, with no spin-up.
- EOT: eot=1, casdout=0, playing=0. Stays until rewind or reset.
- rewind (any state):
  - next cycle: position=0, eot=0, rd_req=0, size relatched, state=IDLE;
  - any outstanding ack is ignored;
  - rewind has priority over a simultaneous rd_ack.
- Half-period counter
  - Counts down from HALF-1 to 0; the transition happens on the 0 cycle.
  - Full bit period is exactly 2*HALF cycles.
  - Counter width is clog2(SPINUP) so it can also serve the spin-up.
- position does not wrap: it saturates at size, and eot fires.

Decomposition:
- Shared package cas_pkg: state enum (IDLE, SPIN, FETCH, WAIT, BITHI, BITLO, EOT), default HALF0/HALF1/SPINUP constants, audio level constant.
- Sub-module cas_bit_gen
  - Inputs: start, bit value, hold.
  - Outputs: level, done.
  - Contains the half-period counter and level generation.
- The top level keeps the fetch FSM, the shift register and position.

Test Plan (SPINUP=16, HALF0=6, HALF1=3 on the bench):
1. Spin-up and first bit: size=1, image {8'h01}, motor=1.
   - rd_req rises 17 cycles after motor; ack after 3 cycles.
   - casdout: 3 high/3 low, then seven times 6 high/6 low.
   - Then eot=1, position=1.
2. Byte sequence: image {8'h55, 8'hAA}, random ack latency 1-10 cycles.
   - Decoded bit stream 1,0,1,0,1,0,1,0 then 0,1,0,1,0,1,0,1.
   - rd_addr 0 then 1; rd_req never high while shifting.
3. Motor pause: drop motor for 50 cycles mid-BITHI of a 0 bit after 2 high cycles.
   - casdout stays 1 throughout.
   - After resume exactly 4 more high cycles; no new spin-up.
4. Motor drop in WAIT: ack arrives with motor=0.
   - Byte is latched and position increments.
   - casdout stays 0 until motor=1, then the bit starts immediately.
5. Rewind at byte 1 of 3, coincident with rd_ack.
   - Ack is ignored; position=0, eot=0, state IDLE.
   - The next motor-on replays from rd_addr=0 after spin-up.
6. Empty image and reset: size=0 with motor=1 -> eot=1 next cycle, rd_req never asserted. reset=0 mid-BITHI -> all outputs reach their reset values on the next clk.

Source files
------------

// File: rtl/cas_pkg.sv
// Shared definitions for the virtual cassette deck: player states and default
// FSK timing constants for a 42.954 MHz system clock.
package cas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPIN,
    FETCH,
    WAIT,
    BITHI,
    BITLO,
    EOT
  } cas_state_e;

  localparam int DEF_HALF0  = 17898;
  localparam int DEF_HALF1  = 8949;
  localparam int DEF_SPINUP = 21477273;

  localparam logic [11:0] AUDIO_HI = 12'h400;

endpackage

// File: rtl/cas_player_if.sv
// Tape image read port: the player requests one byte at a time and holds the
// request until the buffer acknowledges with the data.
interface cas_player_if #(parameter int AW = 24);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_ack;

  modport master (output rd_req, rd_addr, input rd_data, rd_ack);
  modport slave  (input rd_req, rd_addr, output rd_data, rd_ack);
endinterface

// File: rtl/cas_bit_gen.sv
// Half-period down-counter and output level for one FSK bit (high half then
// low half), also reused as the silent motor spin-up timer.
module cas_bit_gen
  import cas_pkg::*;
#(
  parameter int HALF0  = DEF_HALF0,
  parameter int HALF1  = DEF_HALF1,
  parameter int SPINUP = DEF_SPINUP
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic spin,
  input  logic bit_val,
  input  logic hold,
  input  logic clear,
  output logic level,
  output logic done,
  output logic busy
);

  localparam int MAXC = (SPINUP > HALF0) ? ((SPINUP > HALF1) ? SPINUP : HALF1)
                                         : ((HALF0 > HALF1) ? HALF0 : HALF1);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hi_q, hi_d;
  logic          bit_q, bit_d;
  logic          busy_q, busy_d;

  function automatic logic [CW-1:0] half_load(input logic b);
    return b ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
  endfunction

  // done marks the last cycle of a half (or of the spin-up); hold freezes it.
  assign done  = busy_q && (cnt_q == '0) && !hold;
  assign level = hi_q;
  assign busy  = busy_q;

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    bit_d  = bit_q;
    busy_d = busy_q;
    if (clear) begin
      busy_d = 1'b0;
      hi_d   = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      bit_d  = bit_val;
      if (spin) begin
        hi_d  = 1'b0;
        cnt_d = CW'(SPINUP - 1);
      end else begin
        hi_d  = 1'b1;
        cnt_d = half_load(bit_val);
      end
    end else if (busy_q && !hold) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (hi_q) begin
        hi_d  = 1'b0;
        cnt_d = half_load(bit_q);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      hi_q   <= 1'b0;
      bit_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      bit_q  <= bit_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/cas_player.sv
// Cassette player top: fetches image bytes, shifts them out LSB first as
// CoCo/Dragon FSK on casdout, gated by the motor relay.
module cas_player
  import cas_pkg::*;
#(
  parameter int HALF0  = DEF_HALF0,
  parameter int HALF1  = DEF_HALF1,
  parameter int SPINUP = DEF_SPINUP,
  parameter int AW     = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          motor,
  input  logic          rewind,
  input  logic [AW-1:0] file_size,
  cas_player_if.master  rd,
  output logic          casdout,
  output logic [11:0]   audio,
  output logic          playing,
  output logic          eot,
  output logic [AW-1:0] position
);

  cas_state_e    state_q, state_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [AW-1:0] size_q, size_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bitcnt_q, bitcnt_d;

  logic gen_start, gen_spin, gen_bit, gen_hold, gen_clear;
  logic gen_level, gen_done, gen_busy;

  cas_bit_gen #(.HALF0(HALF0), .HALF1(HALF1), .SPINUP(SPINUP)) u_bit_gen (
    .clk     (clk),
    .reset   (reset),
    .start   (gen_start),
    .spin    (gen_spin),
    .bit_val (gen_bit),
    .hold    (gen_hold),
    .clear   (gen_clear),
    .level   (gen_level),
    .done    (gen_done),
    .busy    (gen_busy)
  );

  assign rd.rd_req  = rd_req_q;
  assign rd.rd_addr = pos_q;
  assign casdout    = gen_level;
  assign audio      = gen_level ? AUDIO_HI : 12'h000;
  assign eot        = (state_q == EOT);
  assign playing    = (state_q == SPIN) || (state_q == FETCH) || (state_q == WAIT) ||
                      (state_q == BITHI) || (state_q == BITLO);
  assign position   = pos_q;

  always_comb begin
    state_d   = state_q;
    rd_req_d  = rd_req_q;
    pos_d     = pos_q;
    size_d    = size_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    gen_start = 1'b0;
    gen_spin  = 1'b0;
    gen_bit   = shreg_q[0];
    gen_clear = 1'b0;
    gen_hold  = ((state_q == BITHI) || (state_q == BITLO)) && !motor;

    if (rewind) begin
      state_d   = IDLE;
      pos_d     = '0;
      rd_req_d  = 1'b0;
      size_d    = file_size;
      gen_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (motor) begin
            if (pos_q < size_q) begin
              state_d   = SPIN;
              gen_start = 1'b1;
              gen_spin  = 1'b1;
            end else begin
              state_d = EOT;
            end
          end
        end
        SPIN: begin
          if (!motor) begin
            state_d   = IDLE;
            gen_clear = 1'b1;
          end else if (gen_done) begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          rd_req_d = 1'b1;
          state_d  = WAIT;
        end
        WAIT: begin
          if (rd.rd_ack) begin
            rd_req_d  = 1'b0;
            shreg_d   = rd.rd_data;
            bitcnt_d  = '0;
            pos_d     = pos_q + 1'b1;
            state_d   = BITHI;
            gen_bit   = rd.rd_data[0];
            gen_start = motor;
          end
        end
        BITHI: begin
          // An ack taken with the motor off leaves the bit unstarted until motor-on.
          if (!gen_busy) begin
            gen_start = motor;
          end else if (gen_done) begin
            state_d = BITLO;
          end
        end
        BITLO: begin
          if (gen_done) begin
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) begin
              state_d = (pos_q < size_q) ? FETCH : EOT;
            end else begin
              state_d   = BITHI;
              gen_start = 1'b1;
              gen_bit   = shreg_q[1];
            end
          end
        end
        EOT: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_req_q <= 1'b0;
      pos_q    <= '0;
      size_q   <= file_size;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= rd_req_d;
      pos_q    <= pos_d;
      size_q   <= size_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// Scoreboard bench for cas_player: the image responder queues expected bits,
// a negedge monitor decodes casdout and fetch addresses against the queues.
module tb_cas_player;

  localparam int AW     = 24;
  localparam int HALF0  = 6;
  localparam int HALF1  = 3;
  localparam int SPINUP = 16;

  logic          clk;
  logic          reset;
  logic          motor;
  logic          rewind;
  logic [AW-1:0] file_size;
  logic          casdout;
  logic [11:0]   audio;
  logic          playing;
  logic          eot;
  logic [AW-1:0] position;

  cas_player_if #(.AW(AW)) rd_if ();

  cas_player #(.HALF0(HALF0), .HALF1(HALF1), .SPINUP(SPINUP), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .motor     (motor),
    .rewind    (rewind),
    .file_size (file_size),
    .rd        (rd_if),
    .casdout   (casdout),
    .audio     (audio),
    .playing   (playing),
    .eot       (eot),
    .position  (position)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] img [0:3];
  bit         exp_bits [$];
  int         exp_addr [$];
  int         fix_lat   = 3;
  bit         rand_lat  = 0;
  int         rew_addr  = -1;
  bit         rew_fired = 0;
  int         req_rises = 0;
  bit         req_shift = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return eot;
      1: return casdout;
      2: return rd_if.rd_req;
      3: return !rd_if.rd_req;
      4: return rew_fired;
      default: return rd_if.rd_req && (rd_if.rd_addr == 1);
    endcase
  endfunction

  task automatic wait_cond(input string nm, input int kind, input int budget);
    int n = 0;
    while (!cond(kind) && n < budget) begin
      step();
      n++;
    end
    chk(nm, cond(kind), 1'b1);
  endtask

  task automatic pulse_rewind();
    rewind = 1'b1;
    step();
    rewind = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_casdout"},  casdout, 1'b0);
    chk({tag, "_audio"},    audio, 12'h000);
    chk({tag, "_rd_req"},   rd_if.rd_req, 1'b0);
    chk({tag, "_rd_addr"},  rd_if.rd_addr, 0);
    chk({tag, "_position"}, position, 0);
    chk({tag, "_playing"},  playing, 1'b0);
    chk({tag, "_eot"},      eot, 1'b0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_bits_left"},  exp_bits.size(), 0);
    chk({tag, "_addrs_left"}, exp_addr.size(), 0);
  endtask

  // Image buffer responder: acks each request after a latency and queues the
  // byte's bits LSB first; one chosen address is instead acked under rewind.
  initial begin
    int         lat;
    logic [AW-1:0] a;
    bit         fired;
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_data = 8'h00;
    forever begin
      step();
      if (reset && rd_if.rd_req && !rd_if.rd_ack) begin
        lat = rand_lat ? int'($urandom_range(1, 10)) : fix_lat;
        a   = rd_if.rd_addr;
        repeat (lat - 1) step();
        if (rd_if.rd_req) begin
          fired         = 1'b0;
          rd_if.rd_data = img[a[1:0]];
          rd_if.rd_ack  = 1'b1;
          if (int'(a) == rew_addr) begin
            rewind   = 1'b1;
            rew_addr = -1;
            fired    = 1'b1;
          end else begin
            for (int b = 0; b < 8; b++) exp_bits.push_back(img[a[1:0]][b]);
          end
          step();
          rd_if.rd_ack = 1'b0;
          if (fired) begin
            rewind    = 1'b0;
            rew_fired = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: decodes high/low run lengths (counting only motor-on cycles) and
  // fetch starts, checking each against the scoreboard queues.
  initial begin
    int hi_len = 0, lo_len = 0, prev_hi = 0, bidx = 0, nbit = 0;
    bit prev_casd = 0, have_prev = 0, prev_req = 0, eb;
    int ea;
    forever begin
      @(negedge clk);
      if (!reset || rewind) begin
        hi_len = 0; lo_len = 0; have_prev = 0; bidx = 0;
      end else begin
        if (rd_if.rd_req && !prev_req) begin
          req_rises++;
          if (exp_addr.size() == 0) begin
            chk("fetch_unexpected", rd_if.rd_addr, 32'hFFFF_FFFF);
          end else begin
            ea = exp_addr.pop_front();
            $display("fetch addr=%0d expected=%0d", rd_if.rd_addr, ea);
            chk("rd_addr", rd_if.rd_addr, ea);
          end
        end
        if (casdout && rd_if.rd_req) req_shift = 1'b1;
        if (casdout) begin
          if (!prev_casd) begin
            if (have_prev && bidx != 0) chk("bit_low_len", lo_len, prev_hi);
            chk("audio_hi", audio, 12'h400);
            hi_len = 0;
          end
          if (motor) hi_len++;
        end else begin
          if (prev_casd) begin
            if (exp_bits.size() == 0) begin
              chk("bit_unexpected", hi_len, 0);
            end else begin
              eb = exp_bits.pop_front();
              $display("bit %0d high=%0d expected_bit=%0d", nbit, hi_len, eb);
              chk("bit_high_len", hi_len, eb ? HALF1 : HALF0);
            end
            chk("audio_lo", audio, 12'h000);
            nbit++;
            prev_hi   = hi_len;
            have_prev = 1'b1;
            bidx      = (bidx + 1) % 8;
            lo_len    = 0;
          end
          if (motor) lo_len++;
        end
      end
      prev_casd = casdout;
      prev_req  = rd_if.rd_req;
    end
  end

  initial begin
    int n;
    bit ok;
    reset     = 1'b0;
    motor     = 1'b0;
    rewind    = 1'b0;
    file_size = 1;
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    repeat (3) step();
    check_reset_vals("reset");
    reset = 1'b1;
    step();

    // 1: spin-up latency, single byte 0x01, end of tape
    exp_addr.push_back(0);
    fix_lat = 3;
    motor   = 1'b1;
    step();
    n = 0;
    while (!rd_if.rd_req && n < 100) begin
      step();
      n++;
    end
    chk("t1_req_edges_after_motor", n, 17);
    wait_cond("t1_eot_wait", 0, 500);
    chk("t1_eot", eot, 1'b1);
    chk("t1_position", position, 1);
    chk("t1_playing", playing, 1'b0);
    check_drained("t1");

    // 2: two bytes with random ack latency
    motor = 1'b0;
    img[0] = 8'h55; img[1] = 8'hAA;
    file_size = 2;
    pulse_rewind();
    chk("t2_eot_cleared", eot, 1'b0);
    exp_addr.push_back(0);
    exp_addr.push_back(1);
    rand_lat  = 1'b1;
    req_shift = 1'b0;
    motor     = 1'b1;
    wait_cond("t2_eot_wait", 0, 2000);
    chk("t2_position", position, 2);
    chk("t2_req_while_shift", req_shift, 1'b0);
    check_drained("t2");

    // 3: motor pause in the high half of a 0 bit
    motor = 1'b0;
    img[0] = 8'h00;
    file_size = 1;
    pulse_rewind();
    exp_addr.push_back(0);
    rand_lat = 1'b0;
    fix_lat  = 2;
    motor    = 1'b1;
    wait_cond("t3_first_high", 1, 200);
    step();
    step();
    motor = 1'b0;
    n  = req_rises;
    ok = 1'b1;
    repeat (50) begin
      if (!casdout) ok = 1'b0;
      step();
    end
    chk("t3_level_held", ok, 1'b1);
    chk("t3_playing_paused", playing, 1'b1);
    motor = 1'b1;
    n = 0;
    while (casdout && n < 100) begin
      n++;
      step();
    end
    chk("t3_resume_high_cycles", n, 4);
    wait_cond("t3_eot_wait", 0, 500);
    check_drained("t3");

    // 4: motor drops while the fetch is outstanding
    motor = 1'b0;
    img[0] = 8'h01;
    pulse_rewind();
    exp_addr.push_back(0);
    fix_lat = 4;
    motor   = 1'b1;
    wait_cond("t4_req", 2, 100);
    motor = 1'b0;
    wait_cond("t4_ack_taken", 3, 50);
    chk("t4_position", position, 1);
    ok = 1'b1;
    repeat (20) begin
      if (casdout) ok = 1'b0;
      step();
    end
    chk("t4_silent_while_off", ok, 1'b1);
    chk("t4_playing", playing, 1'b1);
    motor = 1'b1;
    step();
    chk("t4_start_immediate", casdout, 1'b1);
    wait_cond("t4_eot_wait", 0, 500);
    check_drained("t4");

    // 5: rewind coincident with the ack of byte 1 of 3
    motor = 1'b0;
    img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
    file_size = 3;
    pulse_rewind();
    exp_addr.push_back(0);
    exp_addr.push_back(1);
    exp_addr.push_back(0);
    exp_addr.push_back(1);
    exp_addr.push_back(2);
    fix_lat   = 3;
    rew_addr  = 1;
    rew_fired = 1'b0;
    motor     = 1'b1;
    wait_cond("t5_req_addr1", 5, 500);
    motor = 1'b0;
    wait_cond("t5_rewind_fired", 4, 50);
    chk("t5_position", position, 0);
    chk("t5_eot", eot, 1'b0);
    chk("t5_rd_req", rd_if.rd_req, 1'b0);
    chk("t5_idle", playing, 1'b0);
    repeat (10) step();
    chk("t5_ack_ignored", position, 0);
    motor = 1'b1;
    wait_cond("t5_eot_wait", 0, 3000);
    chk("t5_position_end", position, 3);
    check_drained("t5");

    // 6: empty image, then reset in the middle of a high half
    motor = 1'b0;
    file_size = 0;
    pulse_rewind();
    n = req_rises;
    motor = 1'b1;
    step();
    chk("t6_empty_eot", eot, 1'b1);
    repeat (10) step();
    chk("t6_no_fetch", req_rises, n);
    motor = 1'b0;
    img[0] = 8'h00;
    file_size = 1;
    pulse_rewind();
    exp_addr.push_back(0);
    fix_lat = 2;
    motor   = 1'b1;
    wait_cond("t6_high", 1, 200);
    step();
    reset = 1'b0;
    step();
    check_reset_vals("t6_reset");
    exp_bits.delete();
    motor = 1'b0;
    reset = 1'b1;
    step();
    check_drained("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
